// File: rtl/obi_block_copier_pkg.sv
// obi_block_copier_pkg: FSM encoding and bus constants for the OBI block copier.
package obi_block_copier_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } copier_state_e;

    localparam int         WordBytes = 4;
    localparam logic [3:0] FullBe    = 4'hF;

endpackage

// File: rtl/obi_pkg.sv
// obi_pkg: OBI request/response bundles shared by bus initiators and responders.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_block_copier.sv
// obi_block_copier: single-outstanding OBI initiator copying a block of words src -> dst.
// Optional OBI_COPY_FILL_EN adds pattern-fill transfers that skip the read phase.
module obi_block_copier
    import obi_pkg::*;
#(
    parameter int LenWidth  = 16,
    parameter int WordBytes = obi_block_copier_pkg::WordBytes
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [31:0]         src_addr_i,
    input  logic [31:0]         dst_addr_i,
    input  logic [LenWidth-1:0] len_words_i,
    input  logic                abort_i,
`ifdef OBI_COPY_FILL_EN
    input  logic                fill_i,
    input  logic [31:0]         fill_pattern_i,
`endif
    output logic                busy_o,
    output logic                done_o,
    output logic [LenWidth-1:0] words_done_o,
    output obi_req_t            master_req_o,
    input  obi_resp_t           master_resp_i
);
    import obi_block_copier_pkg::*;

    copier_state_e       state_q, state_d;
    logic [31:0]         src_q, dst_q, data_q, start_data;
    logic [LenWidth-1:0] len_q, words_done_q, words_next;
    logic                abort_q, fill_q, start_fill, start_go, wr_done;

`ifdef OBI_COPY_FILL_EN
    assign start_fill = fill_i;
    assign start_data = fill_pattern_i;
`else
    assign start_fill = 1'b0;
    assign start_data = '0;
`endif

    assign start_go     = state_q == IDLE && start_i;
    assign wr_done      = state_q == WR_WAIT && master_resp_i.rvalid;
    assign words_next   = words_done_q + LenWidth'(1);
    assign words_done_o = words_done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = (len_words_i == '0) ? DONE : (start_fill ? WR_REQ : RD_REQ);
            RD_REQ:  if (master_resp_i.gnt) state_d = RD_WAIT;
            RD_WAIT: if (master_resp_i.rvalid) state_d = WR_REQ;
            WR_REQ:  if (master_resp_i.gnt) state_d = WR_WAIT;
            WR_WAIT: if (master_resp_i.rvalid)
                         state_d = (words_next == len_q || abort_q || abort_i) ? DONE
                                 : (fill_q ? WR_REQ : RD_REQ);
            default: state_d = IDLE;
        endcase
    end

    // Abort is only latched while busy so a stale level in IDLE cannot kill the next transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_q        <= '0;
            dst_q        <= '0;
            data_q       <= '0;
            len_q        <= '0;
            words_done_q <= '0;
            abort_q      <= 1'b0;
            fill_q       <= 1'b0;
        end else if (start_go) begin
            src_q        <= src_addr_i & ~32'h3;
            dst_q        <= dst_addr_i & ~32'h3;
            data_q       <= start_data;
            len_q        <= len_words_i;
            words_done_q <= '0;
            abort_q      <= 1'b0;
            fill_q       <= start_fill;
        end else begin
            if (busy_o && abort_i) abort_q <= 1'b1;
            if (state_q == RD_WAIT && master_resp_i.rvalid) data_q <= master_resp_i.rdata;
            if (wr_done) begin
                words_done_q <= words_next;
                src_q        <= src_q + 32'(WordBytes);
                dst_q        <= dst_q + 32'(WordBytes);
            end
        end
    end

    always_comb begin
        master_req_o       = '0;
        master_req_o.req   = state_q == RD_REQ || state_q == WR_REQ;
        master_req_o.we    = state_q == WR_REQ;
        master_req_o.be    = master_req_o.req ? FullBe : 4'h0;
        master_req_o.addr  = state_q == WR_REQ ? dst_q : (state_q == RD_REQ ? src_q : 32'h0);
        master_req_o.wdata = state_q == WR_REQ ? data_q : 32'h0;
        busy_o             = state_q != IDLE && state_q != DONE;
        done_o             = state_q == DONE;
    end

endmodule

// File: tb/tb_obi_block_copier.sv
// tb_obi_block_copier: directed checks of the OBI block copier against a scripted responder.
module tb_obi_block_copier;
    import obi_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, abort_i;
    logic [31:0] src_addr_i, dst_addr_i;
    logic [15:0] len_words_i;
    logic        busy_o, done_o;
    logic [15:0] words_done_o;
    obi_req_t    mreq;
    obi_resp_t   resp;
`ifdef OBI_COPY_FILL_EN
    logic        fill_i = 1'b0;
    logic [31:0] fill_pattern_i = '0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Responder: gnt after gnt_wait stalled cycles, rvalid one cycle after gnt,
    // read data 0xA0 + word index relative to 0x100; every granted access is logged.
    int          gnt_wait = 0;
    int          wait_cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] pend_rdata = '0;
    int          n_wr = 0, n_rd = 0, req_cycles = 0, stab_err = 0, hold_cnt = 0;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    logic [31:0] rd_addr [64];
    logic        hold = 1'b0;
    obi_req_t    held = '0;

    always #5 clk_i = ~clk_i;

    obi_block_copier #(.LenWidth(16)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .src_addr_i    (src_addr_i),
        .dst_addr_i    (dst_addr_i),
        .len_words_i   (len_words_i),
        .abort_i       (abort_i),
`ifdef OBI_COPY_FILL_EN
        .fill_i        (fill_i),
        .fill_pattern_i(fill_pattern_i),
`endif
        .busy_o        (busy_o),
        .done_o        (done_o),
        .words_done_o  (words_done_o),
        .master_req_o  (mreq),
        .master_resp_i (resp)
    );

    always_comb begin
        resp.gnt    = mreq.req && (wait_cnt >= gnt_wait);
        resp.rvalid = pend;
        resp.rdata  = pend_rdata;
    end

    always @(posedge clk_i) begin
        if (rst_i) begin
            pend     <= 1'b0;
            wait_cnt <= 0;
            hold     <= 1'b0;
        end else begin
            pend     <= mreq.req && resp.gnt;
            wait_cnt <= (mreq.req && !resp.gnt) ? wait_cnt + 1 : 0;
            hold     <= mreq.req && !resp.gnt;
            held     <= mreq;
            if (hold) hold_cnt <= hold_cnt + 1;
            if (hold && mreq != held) stab_err <= stab_err + 1;
            if (mreq.req) req_cycles <= req_cycles + 1;
            if (mreq.req && resp.gnt && mreq.we) begin
                wr_addr[n_wr[5:0]] <= mreq.addr;
                wr_data[n_wr[5:0]] <= mreq.wdata;
                n_wr               <= n_wr + 1;
            end
            if (mreq.req && resp.gnt && !mreq.we) begin
                rd_addr[n_rd[5:0]] <= mreq.addr;
                pend_rdata         <= 32'hA0 + ((mreq.addr - 32'h100) >> 2);
                n_rd               <= n_rd + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Latency = edge count from the edge that samples start to the edge that samples done high.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                       input int poke, input logic pst, input logic pab, output int lat);
        int cyc;
        @(negedge clk_i);
        src_addr_i  = s;
        dst_addr_i  = d;
        len_words_i = n;
        start_i     = 1'b1;
        @(posedge clk_i);
        cyc = 1;
        @(negedge clk_i);
        start_i = 1'b0;
        while (!done_o && cyc < 1000) begin
            if (cyc == poke) begin
                start_i    = pst;
                abort_i    = pab;
                src_addr_i = 32'h140;
            end
            @(posedge clk_i);
            cyc++;
            @(negedge clk_i);
            start_i = 1'b0;
            abort_i = 1'b0;
        end
        lat = done_o ? cyc + 1 : -1;
    endtask

    initial begin
        int lat, bw, br, rc;
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        src_addr_i = '0; dst_addr_i = '0; len_words_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_done", 32'(done_o), 0);
        check("rst_words", 32'(words_done_o), 0);
        check("rst_req_nonzero", 32'(|mreq), 0);
        rst_i = 1'b0;

        bw = n_wr; br = n_rd;
        run(32'h100, 32'h8000, 16'd4, -1, 1'b0, 1'b0, lat);
        check("copy4_latency", lat, 18);
        check("copy4_words", 32'(words_done_o), 4);
        check("copy4_busy_at_done", 32'(busy_o), 0);
        check("copy4_nwr", n_wr - bw, 4);
        for (int i = 0; i < 4; i++) begin
            check("copy4_waddr", wr_addr[bw + i], 32'h8000 + 32'(4 * i));
            check("copy4_wdata", wr_data[bw + i], 32'hA0 + 32'(i));
            check("copy4_raddr", rd_addr[br + i], 32'h100 + 32'(4 * i));
        end
        @(negedge clk_i);
        check("copy4_done_pulse", 32'(done_o), 0);
        check("copy4_words_hold", 32'(words_done_o), 4);

        rc = req_cycles; bw = n_wr; br = n_rd;
        run(32'h100, 32'h8000, 16'd0, -1, 1'b0, 1'b0, lat);
        check("len0_latency", lat, 2);
        check("len0_req_cycles", req_cycles - rc, 0);
        check("len0_words", 32'(words_done_o), 0);

        gnt_wait = 3; bw = n_wr;
        run(32'h100, 32'h8300, 16'd2, -1, 1'b0, 1'b0, lat);
        check("stall_latency", lat, 22);
        check("stall_wdata0", wr_data[bw], 32'hA0);
        check("stall_wdata1", wr_data[bw + 1], 32'hA1);
        check("stall_waddr1", wr_addr[bw + 1], 32'h8304);
        check("stall_stable", stab_err, 0);
        check("stall_held_cycles", hold_cnt, 12);
        gnt_wait = 0;

        bw = n_wr; br = n_rd;
        run(32'h100, 32'h8100, 16'd3, 3, 1'b1, 1'b0, lat);
        check("restart_latency", lat, 14);
        check("restart_words", 32'(words_done_o), 3);
        check("restart_nrd", n_rd - br, 3);
        check("restart_raddr2", rd_addr[br + 2], 32'h108);
        check("restart_waddr2", wr_addr[bw + 2], 32'h8108);

        bw = n_wr;
        run(32'h100, 32'h8200, 16'd8, 6, 1'b0, 1'b1, lat);
        check("abort_latency", lat, 10);
        check("abort_words", 32'(words_done_o), 2);
        check("abort_nwr", n_wr - bw, 2);
        check("abort_wdata1", wr_data[bw + 1], 32'hA1);
        check("abort_waddr1", wr_addr[bw + 1], 32'h8204);

        bw = n_wr; br = n_rd;
        run(32'h103, 32'hFFFF_FFFE, 16'd2, -1, 1'b0, 1'b0, lat);
        check("wrap_raddr0", rd_addr[br], 32'h100);
        check("wrap_waddr0", wr_addr[bw], 32'hFFFF_FFFC);
        check("wrap_waddr1", wr_addr[bw + 1], 32'h0);
        check("wrap_wdata1", wr_data[bw + 1], 32'hA1);

        @(negedge clk_i);
        src_addr_i = 32'h100; dst_addr_i = 32'h8500; len_words_i = 16'd8; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("midrst_busy_before", 32'(busy_o), 1);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midrst_busy", 32'(busy_o), 0);
        check("midrst_done", 32'(done_o), 0);
        check("midrst_words", 32'(words_done_o), 0);
        check("midrst_req_nonzero", 32'(|mreq), 0);
        rst_i = 1'b0;

`ifdef OBI_COPY_FILL_EN
        bw = n_wr; br = n_rd;
        fill_i = 1'b1; fill_pattern_i = 32'hDEAD_BEEF;
        run(32'h100, 32'h8400, 16'd3, -1, 1'b0, 1'b0, lat);
        fill_i = 1'b0;
        check("fill_latency", lat, 8);
        check("fill_nrd", n_rd - br, 0);
        check("fill_nwr", n_wr - bw, 3);
        for (int i = 0; i < 3; i++) begin
            check("fill_wdata", wr_data[bw + i], 32'hDEAD_BEEF);
            check("fill_waddr", wr_addr[bw + i], 32'h8400 + 32'(4 * i));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/obi_block_copier.md
Name: obi_block_copier

Overview:
- OBI initiator that copies a contiguous block of 32-bit words from a source address to a destination address over a single OBI master port.
- Sits on the system bus as a master, in front of SRAM bank responders, and offloads memcpy-style transfers from the core.
- Exactly one transaction is outstanding at any time: read word, write word, advance.

Parameters:
- LenWidth, 16, width of the word-count register; maximum transfer is 2^LenWidth-1 words.
- WordBytes, 4, address increment per word; fixed to 4 for 32-bit OBI.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  single-cycle start pulse; sampled only in IDLE
- src_addr_i  in  32  source byte address; bits [1:0] ignored
- dst_addr_i  in  32  destination byte address; bits [1:0] ignored
- len_words_i  in  LenWidth  number of words to copy
- abort_i  in  1  level; finish the in-flight transaction, then stop
- busy_o  out  1  high from the cycle after start until DONE
- done_o  out  1  one-cycle pulse at end of transfer or abort
- words_done_o  out  LenWidth  number of words fully written
- master_req_o  out  obi_req_t  OBI request: req, we, be, addr, wdata
- master_resp_i  in  obi_resp_t  OBI response: gnt, rvalid, rdata

Behaviour:
- Interface: one clock clk_i; reset rst_i is synchronous and active-high.
- Reset, sampled on a clk_i edge, applies at any time including mid-operation:
  - state=IDLE; counters and address registers cleared.
  - Outputs: busy_o=0, done_o=0, words_done_o=0, master_req_o all zeros (req=0, we=0, be=0, addr=0, wdata=0).
  - No pending rvalid is awaited after reset.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE:
  - On start_i, latch {src[31:2],2'b00}, {dst[31:2],2'b00} and len.
  - If len==0, go to DONE; otherwise go to RD_REQ.
  - start_i in any other state is ignored.
- RD_REQ: req=1, we=0, be=4'hF, addr=src_q. Request is held stable until gnt; go to RD_WAIT on gnt (same-cycle gnt allowed).
- RD_WAIT: req=0. On rvalid, capture rdata into data_q and go to WR_REQ.
- WR_REQ: req=1, we=1, be=4'hF, addr=dst_q, wdata=data_q. Held until gnt; then go to WR_WAIT.
- WR_WAIT: req=0. On rvalid:
  - words_done+1, src_q+=4, dst_q+=4.
  - If words_done+1==len_q or abort seen, go to DONE; else go to RD_REQ.
- DONE: done_o=1 for one cycle, busy_o=0, then IDLE. words_done_o holds its value until the next start.
- abort_i is sticky once sampled while busy. It is acted on only at the WR_WAIT completion point, so a word is never left half-copied. Abort in RD_REQ/RD_WAIT still completes that word's write.
- Address arithmetic is 32-bit modulo; wrap past 0xFFFF_FFFC is to 0x0000_0000 with no error.
- Throughput against a zero-wait responder (gnt same cycle, rvalid next cycle): 4 cycles per word; start-to-done latency = 4*len+2 cycles.
- rvalid received in a non-WAIT state is ignored. rdata is used only in RD_WAIT.
- busy_o = (state != IDLE && state != DONE).

Optional Feature:
- Macro: OBI_COPY_FILL_EN.
- Defined:
  - Adds input fill_i (1, sampled with start_i) and input fill_pattern_i (32).
  - Fill transfers skip RD_REQ/RD_WAIT: the FSM goes IDLE→WR_REQ with wdata=fill_pattern latched at start. 2 cycles per word; src_addr_i is ignored.
- Undefined: ports absent; every transfer is a copy.

Decomposition:
- Package obi_block_copier_pkg holds:
  - the state enum copier_state_e (3-bit);
  - localparam WordBytes=4;
  - localparam FullBe=4'hF.
- obi_req_t/obi_resp_t come from obi_pkg.
- Single module; no sub-module is warranted. The FSM, address counters and data register are small enough to stay flat.

Test Plan:
- Copy len=4, src=0x100, dst=0x8000, zero-wait responder preloaded with 0xA0..0xA3 -> dst words equal 0xA0..0xA3; done_o pulse at cycle 18 after start; words_done_o=4.
- len=0 -> done_o two cycles after start; no master_req_o.req ever asserted.
- Responder withholds gnt for 3 cycles on every request, len=2 -> address/we/wdata stable while req high; data correct; latency 4*2+2+12=22.
- start_i re-pulsed while busy with different src -> ignored; original transfer completes unchanged.
- abort_i pulsed during the RD_WAIT of word 2 of len=8 -> word 2 is still written; done_o follows; words_done_o=2 (counting from 1).
- With OBI_COPY_FILL_EN, fill_i=1, pattern 0xDEADBEEF, len=3 -> three writes of 0xDEADBEEF, zero reads, done at cycle 8.
